regfile_sb: RTL and testbench

Parametrised multi-read-port register file with a per-register busy scoreboard, the next generation of the team's fixed 8x16 two-read/one-write register file. It holds the CPU's architectural registers, forwards same-cycle writeback data, and tracks registers with an outstanding producer so the issue stage can detect hazards. It sits between the decode/issue stage (reads, reservations) and the writeback stage (writes).

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_sb_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 66 ++++++
 rtl/regfile_sb.sv | 75 +++++++
 tb/tb_regfile_sb.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and busy-count helper for the regfile_sb register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned DEF_NUM_RD = 2;

  typedef enum logic [1:0] {
    CntHold,
    CntInc,
    CntDec
  } cnt_op_e;

  // A reserve that sets a clear bit and a write that clears a set bit cancel out.
  function automatic cnt_op_e busy_cnt_op(input logic set_bit, input logic clr_bit);
    if (set_bit && !clr_bit) begin
      return CntInc;
    end else if (clr_bit && !set_bit) begin
      return CntDec;
    end
    return CntHold;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read / writeback / reservation bus of regfile_sb; master is the pipeline, slave the regfile.
import regfile_pkg::*;

interface regfile_sb_if #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = DEF_NUM_RD
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ok;
  logic [DEPTH-1:0]         busy_vec;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ok, busy_vec, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ok, busy_vec, busy_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits, reservation acceptance and busy count for regfile_sb.
import regfile_pkg::*;

module regfile_scoreboard #(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter bit          ZERO_R0 = 1'b0,
  localparam int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [DEPTH-1:0]  busy_vec,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             wr_eff, rsv_zero, rsv_set, cnt_inc, cnt_dec;

  assign wr_eff   = wr_en && !(ZERO_R0 && (wr_addr == '0));
  assign rsv_zero = ZERO_R0 && (rsv_addr == '0);
  assign rsv_ok   = rsv_en && (rsv_zero || !busy_q[rsv_addr] ||
                               (wr_en && (wr_addr == rsv_addr)));
  assign rsv_set  = rsv_ok && !rsv_zero;

  // Write and reserve to the same register leave it busy, so that write clears nothing.
  assign cnt_inc = rsv_set && !busy_q[rsv_addr];
  assign cnt_dec = wr_eff && busy_q[wr_addr] && !(rsv_set && (rsv_addr == wr_addr));

  always_comb begin
    busy_d = busy_q;
    if (wr_eff) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_set) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case (busy_cnt_op(cnt_inc, cnt_dec))
      CntInc:  cnt_d = cnt_q + 1'b1;
      CntDec:  cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with busy scoreboard.
// Optional same-cycle writeback forwarding when REGFILE_BYPASS_EN is defined.
import regfile_pkg::*;

module regfile_sb #(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned NUM_RD  = DEF_NUM_RD,
  parameter bit          ZERO_R0 = 1'b0,
  localparam int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic                     wr_eff;
  logic [ADDR_W-1:0]        rd_a;
  logic                     rd_zero;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  assign wr_eff = bus.wr_en && !(ZERO_R0 && (bus.wr_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_eff) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .rsv_ok   (bus.rsv_ok),
    .busy_vec (bus.busy_vec),
    .busy_cnt (bus.busy_cnt)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_a    = '0;
    rd_zero = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_a    = bus.rd_addr[i*ADDR_W +: ADDR_W];
      rd_zero = ZERO_R0 && (rd_a == '0);
      if (!rd_zero) begin
        rd_data[i*DATA_W +: DATA_W] = mem_q[rd_a];
        rd_busy[i]                  = bus.busy_vec[rd_a];
`ifdef REGFILE_BYPASS_EN
        if (bus.wr_en && (bus.wr_addr == rd_a)) begin
          rd_data[i*DATA_W +: DATA_W] = bus.wr_data;
          rd_busy[i]                  = 1'b0;
        end
`endif
      end
    end
  end

  assign bus.rd_data = rd_data;
  assign bus.rd_busy = rd_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb: one instance with ZERO_R0=0, one with ZERO_R0=1.
module tb_regfile_sb;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  regfile_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) rf ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) rz ();

  regfile_sb #(
    .DATA_W  (16),
    .ADDR_W  (3),
    .NUM_RD  (2),
    .ZERO_R0 (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf)
  );

  regfile_sb #(
    .DATA_W  (16),
    .ADDR_W  (3),
    .NUM_RD  (2),
    .ZERO_R0 (1'b1)
  ) dut_z (
    .clk (clk),
    .rst (rst),
    .bus (rz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1);
    rf.rd_addr = {a1, a0};
    #1;
  endtask

  task automatic idle_rf();
    rf.wr_en = 1'b0; rf.wr_addr = '0; rf.wr_data = '0;
    rf.rsv_en = 1'b0; rf.rsv_addr = '0;
  endtask

  task automatic reserve(input logic [2:0] a);
    rf.rsv_en = 1'b1; rf.rsv_addr = a;
    #1;
    check("rsv_ok_accept", {31'd0, rf.rsv_ok}, 32'd1);
    tick();
    rf.rsv_en = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    idle_rf();
    rf.rd_addr = '0;
    rz.rd_addr = '0; rz.wr_en = 1'b0; rz.wr_addr = '0; rz.wr_data = '0;
    rz.rsv_en = 1'b0; rz.rsv_addr = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state across all registers on both ports
    check("reset_busy_cnt", {28'd0, rf.busy_cnt}, 32'd0);
    check("reset_busy_vec", {24'd0, rf.busy_vec}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      set_rd(3'(i), 3'(7 - i));
      check("reset_rd0", {16'd0, rf.rd_data[15:0]}, 32'd0);
      check("reset_rd1", {16'd0, rf.rd_data[31:16]}, 32'd0);
    end

    // Write r0 then r1; read r1 during its write
    rf.wr_en = 1'b1; rf.wr_addr = 3'd0; rf.wr_data = 16'h1234;
    tick();
    rf.wr_addr = 3'd1; rf.wr_data = 16'h5678;
    set_rd(3'd0, 3'd1);
    check("r0_after_write", {16'd0, rf.rd_data[15:0]}, 32'h1234);
`ifdef REGFILE_BYPASS_EN
    check("r1_bypass", {16'd0, rf.rd_data[31:16]}, 32'h5678);
`else
    check("r1_no_bypass", {16'd0, rf.rd_data[31:16]}, 32'h0000);
`endif
    tick();
    idle_rf();
    set_rd(3'd0, 3'd1);
    check("r0_read", {16'd0, rf.rd_data[15:0]}, 32'h1234);
    check("r1_read", {16'd0, rf.rd_data[31:16]}, 32'h5678);

    // Reserve r3, retry rejected, then write clears it
    reserve(3'd3);
    check("busy_vec_r3", {24'd0, rf.busy_vec}, 32'h08);
    check("busy_cnt_1", {28'd0, rf.busy_cnt}, 32'd1);
    rf.rsv_en = 1'b1; rf.rsv_addr = 3'd3;
    set_rd(3'd3, 3'd3);
    check("rsv_ok_reject", {31'd0, rf.rsv_ok}, 32'd0);
    check("rd_busy_r3", {30'd0, rf.rd_busy}, 32'd3);
    tick();
    rf.rsv_en = 1'b0;
    check("busy_cnt_hold", {28'd0, rf.busy_cnt}, 32'd1);
    rf.wr_en = 1'b1; rf.wr_addr = 3'd3; rf.wr_data = 16'hBEEF;
    set_rd(3'd3, 3'd1);
`ifdef REGFILE_BYPASS_EN
    check("r3_bypass_data", {16'd0, rf.rd_data[15:0]}, 32'hBEEF);
    check("r3_bypass_busy", {30'd0, rf.rd_busy}, 32'd0);
`else
    check("r3_stale_data", {16'd0, rf.rd_data[15:0]}, 32'h0000);
    check("r3_stale_busy", {30'd0, rf.rd_busy}, 32'd1);
`endif
    tick();
    idle_rf();
    set_rd(3'd3, 3'd1);
    check("r3_read", {16'd0, rf.rd_data[15:0]}, 32'hBEEF);
    check("busy_vec_clear", {24'd0, rf.busy_vec}, 32'h00);
    check("busy_cnt_0", {28'd0, rf.busy_cnt}, 32'd0);

    // Write and reserve the busy r3 in the same cycle
    reserve(3'd3);
    rf.wr_en = 1'b1; rf.wr_addr = 3'd3; rf.wr_data = 16'h00AA;
    rf.rsv_en = 1'b1; rf.rsv_addr = 3'd3;
    #1;
    check("rsv_ok_same_reg", {31'd0, rf.rsv_ok}, 32'd1);
    tick();
    idle_rf();
    set_rd(3'd3, 3'd0);
    check("r3_00aa", {16'd0, rf.rd_data[15:0]}, 32'h00AA);
    check("busy_vec_same", {24'd0, rf.busy_vec}, 32'h08);
    check("busy_cnt_same", {28'd0, rf.busy_cnt}, 32'd1);

    // Plain write of a non-busy register leaves the count alone
    rf.wr_en = 1'b1; rf.wr_addr = 3'd7; rf.wr_data = 16'hC0DE;
    tick();
    idle_rf();
    set_rd(3'd7, 3'd3);
    check("r7_plain", {16'd0, rf.rd_data[15:0]}, 32'hC0DE);
    check("busy_cnt_plain", {28'd0, rf.busy_cnt}, 32'd1);

    // Reserve r1, r2, r5 then reset with a concurrent write and reserve
    reserve(3'd1);
    reserve(3'd2);
    reserve(3'd5);
    check("busy_vec_multi", {24'd0, rf.busy_vec}, 32'h2E);
    check("busy_cnt_4", {28'd0, rf.busy_cnt}, 32'd4);

    // ZERO_R0 instance: r0 ignores writes and reservations
    rz.wr_en = 1'b1; rz.wr_addr = 3'd0; rz.wr_data = 16'hFFFF;
    rz.rsv_en = 1'b1; rz.rsv_addr = 3'd0;
    #1;
    check("z_rsv_ok_r0", {31'd0, rz.rsv_ok}, 32'd1);
    tick();
    rz.wr_addr = 3'd4; rz.wr_data = 16'h0F0F; rz.rsv_en = 1'b0;
    tick();
    rz.wr_en = 1'b0;
    rz.rd_addr = {3'd4, 3'd0};
    #1;
    check("z_r0_data", {16'd0, rz.rd_data[15:0]}, 32'h0000);
    check("z_r4_data", {16'd0, rz.rd_data[31:16]}, 32'h0F0F);
    check("z_busy_vec", {24'd0, rz.busy_vec}, 32'h00);
    check("z_rd_busy", {30'd0, rz.rd_busy}, 32'd0);
    check("z_busy_cnt", {28'd0, rz.busy_cnt}, 32'd0);

    rst = 1'b1;
    rf.wr_en = 1'b1; rf.wr_addr = 3'd2; rf.wr_data = 16'h5555;
    rf.rsv_en = 1'b1; rf.rsv_addr = 3'd6;
    tick();
    rst = 1'b0;
    idle_rf();
    check("rst_busy_vec", {24'd0, rf.busy_vec}, 32'h00);
    check("rst_busy_cnt", {28'd0, rf.busy_cnt}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      set_rd(3'(i), 3'(i));
      check("rst_rd0", {16'd0, rf.rd_data[15:0]}, 32'd0);
      check("rst_rd1", {16'd0, rf.rd_data[31:16]}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
